// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 sizes, initial hash value and padder state encoding
package sha256_pkg;

  localparam int WORDSIZE  = 32;
  localparam int BLOCKSIZE = 512;
  localparam int HASHSIZE  = 256;

  localparam logic [HASHSIZE-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // ST_FILL/ST_PADBLK/ST_DONE double as the "what follows this block" marker
  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PADBLK = 3'd3,
    ST_DONE   = 3'd4
  } pad_state_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - byte-stream to padded 512-bit block feeder with hash chaining
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter logic [HASHSIZE-1:0] IV       = SHA256_IV,
  parameter int                  LEN_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [BLOCKSIZE-1:0] block,
  output logic                 block_valid,
  output logic [HASHSIZE-1:0]  prev_hash,
  input  logic                 core_ready,
  input  logic [HASHSIZE-1:0]  hash,
  input  logic                 hash_valid,
  output logic [HASHSIZE-1:0]  digest,
  output logic                 digest_valid,
  input  logic                 digest_ready
);

  pad_state_t           state_q, state_d;
  pad_state_t           after_q;    // where to go once the current block is hashed
  logic                 pad80_q;    // pad block must start with 0x80 (message ended on a full block)
  logic [5:0]           idx_q;
  logic [LEN_BITS-1:0]  count_q;    // message byte count; bit length is count*8
  logic [BLOCKSIZE-1:0] blk_q;
  logic [HASHSIZE-1:0]  chain_q;
  logic [HASHSIZE-1:0]  digest_q;

  logic [LEN_BITS-1:0]  count_inc;
  logic [LEN_BITS-1:0]  bits_inc;
  logic [LEN_BITS-1:0]  bits_cur;
  logic [63:0]          len_fill;
  logic [63:0]          len_cur;
  logic [6:0]           n_bytes;
  logic [BLOCKSIZE-1:0] fill_blk;

  assign count_inc = count_q + LEN_BITS'(1);
  assign bits_inc  = count_inc << 3;
  assign bits_cur  = count_q << 3;
  assign len_fill  = 64'(bits_inc);
  assign len_cur   = 64'(bits_cur);
  assign n_bytes   = {1'b0, idx_q} + 7'd1;

  assign block     = blk_q;
  assign prev_hash = chain_q;
  assign digest    = digest_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs, all decoded from the current state
  always_comb begin
    state_d      = state_q;
    s_ready      = 1'b0;
    block_valid  = 1'b0;
    digest_valid = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid && (s_last || idx_q == 6'd63)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        block_valid = 1'b1;
        if (core_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hash_valid) state_d = after_q;
      end
      ST_PADBLK: state_d = ST_ISSUE;
      ST_DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Byte-lane write of the incoming byte plus in-block padding when it is the last one;
  // lanes beyond the byte are already zero because the buffer is cleared per block
  always_comb begin
    fill_blk = blk_q;
    fill_blk[511 - 8*int'(idx_q) -: 8] = s_data;
    if (s_last) begin
      if (n_bytes < 7'd64)  fill_blk[511 - 8*int'(n_bytes) -: 8] = 8'h80;
      if (n_bytes <= 7'd55) fill_blk[63:0] = len_fill;
    end
  end

  // Block buffer, byte index, byte count and follow-on bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      after_q <= ST_FILL;
      pad80_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (s_valid) begin
            blk_q   <= fill_blk;
            idx_q   <= idx_q + 6'd1;
            count_q <= count_inc;
            if (s_last) begin
              after_q <= (n_bytes <= 7'd55) ? ST_DONE : ST_PADBLK;
              pad80_q <= (n_bytes == 7'd64);
            end else begin
              after_q <= ST_FILL;
              pad80_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (hash_valid) begin
            blk_q <= '0;
            idx_q <= '0;
          end
        end
        ST_PADBLK: begin
          blk_q   <= {(pad80_q ? 8'h80 : 8'h00), 440'b0, len_cur};
          after_q <= ST_DONE;
        end
        ST_DONE: begin
          if (digest_ready) count_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Chaining value and final digest capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q  <= IV;
      digest_q <= '0;
    end else if (state_q == ST_WAIT && hash_valid) begin
      chain_q <= hash;
      if (after_q == ST_DONE) digest_q <= hash;
    end else if (state_q == ST_DONE && digest_ready) begin
      chain_q <= IV;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized self-checking bench with a behavioural SHA-256 core
module tb_sha256_msg_padder;

  localparam logic [255:0] IV_REF =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_448 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] block;
  logic         block_valid;
  logic [255:0] prev_hash;
  logic         core_ready = 1'b1;
  logic [255:0] hash = '0;
  logic         hash_valid = 1'b0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_blks[$];
  logic [255:0] exp_dig;
  logic [511:0] blk_log[$];
  logic [255:0] ph_log[$];

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .block(block), .block_valid(block_valid), .prev_hash(prev_hash),
    .core_ready(core_ready), .hash(hash), .hash_valid(hash_valid),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
            e + h[127:96],  f + h[95:64],   g + h[63:32],   hh + h[31:0]};
  endfunction

  // Reference: FIPS 180-4 padding over the whole message, then chained compression
  function automatic void build_model();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] w;
    p = msg_q;
    bits = 64'(msg_q.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_blks.delete();
    exp_dig = IV_REF;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      w = '0;
      for (int i = 0; i < 64; i++) w = {w[503:0], p[64*bi + i]};
      exp_blks.push_back(w);
      exp_dig = compress(exp_dig, w);
    end
  endfunction

  // Behavioural compression core: 65-cycle latency, hash_valid held until next transfer
  int           core_cnt = 0;
  logic [511:0] core_blk = '0;
  logic [255:0] core_h = '0;
  always @(posedge clk) begin
    if (block_valid && core_ready) begin
      blk_log.push_back(block);
      ph_log.push_back(prev_hash);
      core_blk   <= block;
      core_h     <= prev_hash;
      core_ready <= 1'b0;
      hash_valid <= 1'b0;
      core_cnt   <= 65;
    end else if (!core_ready) begin
      if (core_cnt == 1) begin
        hash       <= compress(core_h, core_blk);
        hash_valid <= 1'b1;
        core_ready <= 1'b1;
      end
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic load_string(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic send_msg(input bit gaps, input bit with_last, output bit ok);
    int  g;
    int  guard;
    bit  acc;
    ok = 1'b1;
    for (int i = 0; i < msg_q.size(); i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
        @(posedge clk); #1;
      end
      s_data  = msg_q[i];
      s_last  = with_last && (i == msg_q.size() - 1);
      s_valid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 3000);
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_digest(output logic [255:0] d, output bit ok);
    ok = 1'b0;
    d  = 'x;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (digest_valid === 1'b1) begin
        d  = digest;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_digest();
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; digest_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL reset_block_valid got %b want 0", block_valid); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid got %b want 0", digest_valid); end
    checks++; if (digest !== '0) begin errors++; $display("FAIL reset_digest got %h want 0", digest); end
    checks++; if (block !== '0) begin errors++; $display("FAIL reset_block got %h want 0", block); end
    checks++; if (prev_hash !== IV_REF) begin errors++; $display("FAIL reset_prev_hash got %h want %h", prev_hash, IV_REF); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_abc();
    logic [255:0] d;
    bit ok_s, ok_d;
    load_string("abc"); build_model(); blk_log.delete();
    send_msg(1'b0, 1'b1, ok_s);
    wait_digest(d, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d !== ABC_DIG) begin errors++; $display("FAIL abc_digest got %h want %h", d, ABC_DIG); end
    checks++; if (blk_log.size() != 1) begin errors++; $display("FAIL abc_nblocks got %0d want 1", blk_log.size()); end
    checks++; if (blk_log[0] !== exp_blks[0]) begin errors++; $display("FAIL abc_block got %h want %h", blk_log[0], exp_blks[0]); end
  endtask

  task automatic test_448bit();
    logic [255:0] d;
    bit ok_s, ok_d;
    load_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    build_model(); blk_log.delete();
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d !== DIG_448) begin errors++; $display("FAIL msg56_digest got %h want %h", d, DIG_448); end
    checks++; if (blk_log.size() != 2) begin errors++; $display("FAIL msg56_nblocks got %0d want 2", blk_log.size()); end
    checks++; if (blk_log[1] !== exp_blks[1]) begin errors++; $display("FAIL msg56_padblk got %h want %h", blk_log[1], exp_blks[1]); end
  endtask

  task automatic test_full_block();
    logic [255:0] d;
    bit ok_s, ok_d;
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'h61);
    build_model(); blk_log.delete();
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d !== exp_dig) begin errors++; $display("FAIL a64_digest got %h want %h", d, exp_dig); end
    checks++; if (blk_log.size() != 2) begin errors++; $display("FAIL a64_nblocks got %0d want 2", blk_log.size()); end
    checks++; if (blk_log[0] !== exp_blks[0]) begin errors++; $display("FAIL a64_block0 got %h want %h", blk_log[0], exp_blks[0]); end
    checks++; if (blk_log[1] !== {8'h80, 440'b0, 64'h200}) begin errors++; $display("FAIL a64_padblk got %h want 80..0200", blk_log[1]); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d, d2;
    bit ok_s, ok_d;
    load_random($urandom_range(20, 150)); build_model();
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d, ok_d);
    checks++; if (!ok_s || !ok_d || d !== exp_dig) begin errors++; $display("FAIL stall_digest got %h want %h", d, exp_dig); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (digest_valid !== 1'b1 || digest !== exp_dig || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b rdy=%b d=%h want v=1 rdy=0 d=%h", c, digest_valid, s_ready, digest, exp_dig);
      end
    end
    release_digest();
    load_string("abc");
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d2, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d2 !== ABC_DIG) begin errors++; $display("FAIL b2b_abc_digest got %h want %h", d2, ABC_DIG); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    bit ok_s, ok_d;
    load_random(64); build_model(); blk_log.delete();
    send_msg(1'b0, 1'b0, ok_s);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (!ok_s || blk_log.size() != 1 || blk_log[0] !== exp_blks[0]) begin
      errors++; $display("FAIL midrst_block0 n=%0d got %h want %h", blk_log.size(), blk_log[0], exp_blks[0]);
    end
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1 || block_valid !== 1'b0 || digest_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got rdy=%b bv=%b dv=%b want 1 0 0", s_ready, block_valid, digest_valid);
    end
    checks++; if (prev_hash !== IV_REF || block !== '0 || digest !== '0) begin
      errors++; $display("FAIL midrst_regs got ph=%h want %h", prev_hash, IV_REF);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    blk_log.delete(); ph_log.delete();
    load_string("abc");
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d !== ABC_DIG) begin errors++; $display("FAIL midrst_abc_digest got %h want %h", d, ABC_DIG); end
    checks++; if (ph_log.size() != 1 || ph_log[0] !== IV_REF) begin errors++; $display("FAIL midrst_prev_hash got %h want %h", ph_log[0], IV_REF); end
  endtask

  task automatic test_120();
    logic [255:0] d;
    bit ok_s, ok_d;
    load_random(120); build_model(); blk_log.delete();
    send_msg(1'b1, 1'b1, ok_s);
    wait_digest(d, ok_d); release_digest();
    checks++; if (!ok_s || !ok_d || d !== exp_dig) begin errors++; $display("FAIL m120_digest got %h want %h", d, exp_dig); end
    checks++; if (blk_log.size() != 3) begin errors++; $display("FAIL m120_nblocks got %0d want 3", blk_log.size()); end
    checks++; if (blk_log[1] !== exp_blks[1]) begin errors++; $display("FAIL m120_block1 got %h want %h", blk_log[1], exp_blks[1]); end
    checks++; if (blk_log[2] !== {448'b0, 64'h3C0}) begin errors++; $display("FAIL m120_lenblk got %h want 0..03c0", blk_log[2]); end
  endtask

  task automatic test_lengths();
    int lens[7] = '{1, 55, 56, 63, 65, 127, 128};
    logic [255:0] d;
    bit ok_s, ok_d;
    foreach (lens[k]) begin
      load_random(lens[k]); build_model(); blk_log.delete();
      send_msg(1'($urandom), 1'b1, ok_s);
      wait_digest(d, ok_d); release_digest();
      checks++; if (!ok_s || !ok_d || d !== exp_dig) begin errors++; $display("FAIL len%0d_digest got %h want %h", lens[k], d, exp_dig); end
      checks++; if (blk_log.size() != exp_blks.size()) begin errors++; $display("FAIL len%0d_nblocks got %0d want %0d", lens[k], blk_log.size(), exp_blks.size()); end
      for (int b = 0; b < exp_blks.size(); b++) begin
        checks++; if (blk_log[b] !== exp_blks[b]) begin errors++; $display("FAIL len%0d_block%0d got %h want %h", lens[k], b, blk_log[b], exp_blks[b]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_448bit();
    test_full_block();
    test_back_to_back();
    test_reset_mid();
    test_120();
    test_lengths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
